// File: rtl/instr_mem_bridge_if.sv
// rtl/instr_mem_bridge_if.sv - boot-load stream and instruction fetch bus bundle
//
// Purpose: groups the two handshake buses seen by instr_mem_bridge.
// Signals:
//   load_valid/load_data/load_last -> boot word stream into the bridge
//   load_ready                     <- boot word accepted this cycle
//   instr_req_i/instr_addr_i       -> ibex fetch request and byte address
//   instr_gnt_o                    <- request accepted
//   instr_rvalid_o/instr_rdata_o   <- fetch response
// Modports: master = core/loader side, slave = bridge side.

interface instr_mem_bridge_if;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;

  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;

  modport master (
    output load_valid, load_data, load_last, instr_req_i, instr_addr_i,
    input  load_ready, instr_gnt_o, instr_rvalid_o, instr_rdata_o
  );

  modport slave (
    input  load_valid, load_data, load_last, instr_req_i, instr_addr_i,
    output load_ready, instr_gnt_o, instr_rvalid_o, instr_rdata_o
  );
endinterface

// File: rtl/instr_mem_bridge.sv
// rtl/instr_mem_bridge.sv - boot loader and fetch server for a 1rw1r instruction SRAM
//
// Purpose: boot-loads the instruction RAM through SRAM port 0, then releases
// the core and serves its fetches from SRAM port 1 with one-cycle latency.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   load_start      pulse: restart loading from word 0
//   load_done       high while serving fetches
//   fetch_enable_o  to ibex fetch_enable_i
//   oob_err         sticky, fetch above RAM range seen
//   bus             boot stream + fetch bus (slave side)
//   sram_*0         SRAM write port (csb/web active low)
//   sram_*1         SRAM read port, sram_dout1 valid the cycle after select

module instr_mem_bridge #(
  parameter int ADDR_W     = 8,
  parameter int BOOT_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  output logic              load_done,
  output logic              fetch_enable_o,
  output logic              oob_err,
  instr_mem_bridge_if.slave bus,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [3:0]        sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [31:0]       sram_din0,
  output logic              sram_csb1,
  output logic [ADDR_W-1:0] sram_addr1,
  input  logic [31:0]       sram_dout1
);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // One extra pointer bit so a full 2^ADDR_W load never wraps to 0.
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(BOOT_WORDS - 1);
  localparam logic [31:0]     NOP_INSN = 32'h0000_0013;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [ADDR_W:0] r_wptr;
  logic            r_load_ready;
  logic            r_run_q;
  logic            r_rvalid;
  logic            r_rvalid_oob;
  logic            r_oob_err;

  logic            w_wr;
  logic            w_last;
  logic            w_oob;
  logic            w_gnt;
  logic            w_sel1;
  logic            w_unused_addr;

  // load_ready is only high in LOAD, so it alone qualifies the write.
  assign w_wr   = bus.load_valid & r_load_ready;
  assign w_last = w_wr & (bus.load_last | (r_wptr == LAST_PTR));
  assign w_oob  = |bus.instr_addr_i[31:ADDR_W+2];
  assign w_gnt  = bus.instr_req_i & (r_state == ST_RUN) & ~load_start;
  assign w_sel1 = w_gnt & ~w_oob;

  // Byte offset within a word is irrelevant to a word-wide fetch.
  assign w_unused_addr = ^bus.instr_addr_i[1:0];

  always_comb begin
    w_state_nxt = r_state;
    if (load_start) begin
      // A response still owed to the core is delivered before reloading.
      w_state_nxt = r_rvalid ? ST_DRAIN : ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:  if (w_last) w_state_nxt = ST_RUN;
        ST_DRAIN: if (!r_rvalid) w_state_nxt = ST_LOAD;
        ST_RUN:   w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_LOAD;
      r_wptr       <= '0;
      r_load_ready <= 1'b0;
      r_run_q      <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rvalid_oob <= 1'b0;
      r_oob_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_load_ready <= (w_state_nxt == ST_LOAD);
      // Released one cycle after entering RUN; dropped right after load_start.
      r_run_q      <= (r_state == ST_RUN) & ~load_start;
      r_rvalid     <= w_gnt;
      r_rvalid_oob <= w_gnt & w_oob;
      r_oob_err    <= r_oob_err | (w_gnt & w_oob);
      if (load_start) begin
        r_wptr <= '0;
      end else if (w_wr) begin
        r_wptr <= r_wptr + (ADDR_W+1)'(1);
      end
    end
  end

  assign bus.load_ready     = r_load_ready;
  assign load_done          = r_run_q;
  assign fetch_enable_o     = r_run_q;
  assign oob_err            = r_oob_err;

  assign bus.instr_gnt_o    = w_gnt;
  assign bus.instr_rvalid_o = r_rvalid;
  assign bus.instr_rdata_o  = !r_rvalid    ? 32'h0 :
                              r_rvalid_oob ? NOP_INSN : sram_dout1;

  assign sram_csb0   = ~w_wr;
  assign sram_web0   = ~w_wr;
  assign sram_wmask0 = w_wr ? 4'hF : 4'h0;
  assign sram_addr0  = w_wr ? r_wptr[ADDR_W-1:0] : '0;
  assign sram_din0   = w_wr ? bus.load_data : 32'h0;

  assign sram_csb1   = ~w_sel1;
  assign sram_addr1  = w_sel1 ? bus.instr_addr_i[ADDR_W+1:2] : '0;

endmodule

// File: tb/tb_instr_mem_bridge.sv
// tb/tb_instr_mem_bridge.sv - directed self-checking bench for instr_mem_bridge

module tb_instr_mem_bridge;

  logic        clk;
  logic        reset;
  logic        load_start;
  logic        load_done;
  logic        fetch_enable_o;
  logic        oob_err;
  logic        sram_csb0;
  logic        sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic        sram_csb1;
  logic [7:0]  sram_addr1;
  logic [31:0] sram_dout1 = 32'h0;

  logic [31:0] mem [0:255];
  int          wr_count = 0;
  int          n_tests  = 0;
  int          n_fail   = 0;
  int          base;

  instr_mem_bridge_if bif ();

  instr_mem_bridge #(.ADDR_W(8), .BOOT_WORDS(256)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_start     (load_start),
    .load_done      (load_done),
    .fetch_enable_o (fetch_enable_o),
    .oob_err        (oob_err),
    .bus            (bif.slave),
    .sram_csb0      (sram_csb0),
    .sram_web0      (sram_web0),
    .sram_wmask0    (sram_wmask0),
    .sram_addr0     (sram_addr0),
    .sram_din0      (sram_din0),
    .sram_csb1      (sram_csb1),
    .sram_addr1     (sram_addr1),
    .sram_dout1     (sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1rw1r SRAM: synchronous write on port 0, registered read on port 1.
  always @(posedge clk) begin
    if (!sram_csb0 && !sram_web0) begin
      for (int b = 0; b < 4; b++)
        if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      wr_count <= wr_count + 1;
    end
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0;
    bif.load_valid = 1'b0; bif.load_data = 32'h0; bif.load_last = 1'b0;
    bif.instr_req_i = 1'b0; bif.instr_addr_i = 32'h0;

    // Reset values
    repeat (2) tick;
    #2;
    chk("rst_load_ready", 32'(bif.load_ready), 32'd0);
    chk("rst_load_done",  32'(load_done), 32'd0);
    chk("rst_fetch_en",   32'(fetch_enable_o), 32'd0);
    chk("rst_oob_err",    32'(oob_err), 32'd0);
    chk("rst_rvalid",     32'(bif.instr_rvalid_o), 32'd0);
    chk("rst_rdata",      bif.instr_rdata_o, 32'd0);
    chk("rst_csb0",       32'(sram_csb0), 32'd1);
    chk("rst_web0",       32'(sram_web0), 32'd1);
    chk("rst_wmask0",     32'(sram_wmask0), 32'd0);
    chk("rst_csb1",       32'(sram_csb1), 32'd1);
    tick; reset = 1'b0; #2;
    chk("ready_pre_edge", 32'(bif.load_ready), 32'd0);
    tick; #2;
    chk("ready_post_edge", 32'(bif.load_ready), 32'd1);

    // Boot 4 words, load_last on the fourth
    for (int i = 0; i < 4; i++) begin
      tick;
      bif.load_valid = 1'b1; bif.load_data = 32'hA0A0_0000 + 32'(i); bif.load_last = (i == 3);
      #2;
      chk("a_addr0", 32'(sram_addr0), 32'(i));
      chk("a_din0",  sram_din0, 32'hA0A0_0000 + 32'(i));
      chk("a_csb0",  32'(sram_csb0), 32'd0);
      if (i == 0) begin
        chk("a_web0",   32'(sram_web0), 32'd0);
        chk("a_wmask0", 32'(sram_wmask0), 32'hF);
      end
    end
    tick; bif.load_valid = 1'b0; bif.load_last = 1'b0; #2;
    chk("a_entry_ready", 32'(bif.load_ready), 32'd0);
    chk("a_entry_done",  32'(load_done), 32'd0);
    chk("a_entry_fen",   32'(fetch_enable_o), 32'd0);
    tick; #2;
    chk("a_done", 32'(load_done), 32'd1);
    chk("a_fen",  32'(fetch_enable_o), 32'd1);

    // Three back-to-back fetches at 0x0, 0x4, 0xC
    tick; bif.instr_req_i = 1'b1; bif.instr_addr_i = 32'h0; #2;
    chk("f0_gnt",   32'(bif.instr_gnt_o), 32'd1);
    chk("f0_csb1",  32'(sram_csb1), 32'd0);
    chk("f0_addr1", 32'(sram_addr1), 32'd0);
    chk("f0_rvalid", 32'(bif.instr_rvalid_o), 32'd0);
    tick; bif.instr_addr_i = 32'h4; #2;
    chk("f1_gnt",   32'(bif.instr_gnt_o), 32'd1);
    chk("f1_addr1", 32'(sram_addr1), 32'd1);
    chk("f1_rvalid", 32'(bif.instr_rvalid_o), 32'd1);
    chk("f1_rdata", bif.instr_rdata_o, 32'hA0A0_0000);
    tick; bif.instr_addr_i = 32'hC; #2;
    chk("f2_addr1", 32'(sram_addr1), 32'd3);
    chk("f2_rvalid", 32'(bif.instr_rvalid_o), 32'd1);
    chk("f2_rdata", bif.instr_rdata_o, 32'hA0A0_0001);
    tick; bif.instr_req_i = 1'b0; bif.instr_addr_i = 32'h0; #2;
    chk("f3_gnt",   32'(bif.instr_gnt_o), 32'd0);
    chk("f3_rvalid", 32'(bif.instr_rvalid_o), 32'd1);
    chk("f3_rdata", bif.instr_rdata_o, 32'hA0A0_0003);
    tick; #2;
    chk("f4_rvalid", 32'(bif.instr_rvalid_o), 32'd0);
    chk("f4_oob",    32'(oob_err), 32'd0);

    // Out-of-range fetch
    tick; bif.instr_req_i = 1'b1; bif.instr_addr_i = 32'h400; #2;
    chk("oob_gnt",  32'(bif.instr_gnt_o), 32'd1);
    chk("oob_csb1", 32'(sram_csb1), 32'd1);
    tick; bif.instr_req_i = 1'b0; bif.instr_addr_i = 32'h0; #2;
    chk("oob_rvalid", 32'(bif.instr_rvalid_o), 32'd1);
    chk("oob_rdata",  bif.instr_rdata_o, 32'h0000_0013);
    chk("oob_err_set", 32'(oob_err), 32'd1);
    tick; #2;
    chk("oob_err_sticky", 32'(oob_err), 32'd1);

    // load_start with a response pending from the previous grant
    tick; bif.instr_req_i = 1'b1; bif.instr_addr_i = 32'h8; #2;
    chk("ls_pre_gnt", 32'(bif.instr_gnt_o), 32'd1);
    tick; load_start = 1'b1; bif.instr_addr_i = 32'h4; #2;
    chk("ls_gnt",    32'(bif.instr_gnt_o), 32'd0);
    chk("ls_csb1",   32'(sram_csb1), 32'd1);
    chk("ls_rvalid", 32'(bif.instr_rvalid_o), 32'd1);
    chk("ls_rdata",  bif.instr_rdata_o, 32'hA0A0_0002);
    tick; load_start = 1'b0; bif.instr_req_i = 1'b0; bif.instr_addr_i = 32'h0; #2;
    chk("drain_fen",    32'(fetch_enable_o), 32'd0);
    chk("drain_done",   32'(load_done), 32'd0);
    chk("drain_ready",  32'(bif.load_ready), 32'd0);
    chk("drain_rvalid", 32'(bif.instr_rvalid_o), 32'd0);
    tick; #2;
    chk("ls_load_ready", 32'(bif.load_ready), 32'd1);
    chk("ls_load_fen",   32'(fetch_enable_o), 32'd0);

    // Reset in the middle of a load
    tick; bif.load_valid = 1'b1; bif.load_data = 32'hB0B0_0000; #2;
    chk("b0_addr0", 32'(sram_addr0), 32'd0);
    tick; bif.load_data = 32'hB0B0_0001; #2;
    chk("b1_addr0", 32'(sram_addr0), 32'd1);
    tick; bif.load_valid = 1'b0; reset = 1'b1; #1;
    chk("mrst_ready", 32'(bif.load_ready), 32'd0);
    chk("mrst_csb0",  32'(sram_csb0), 32'd1);
    chk("mrst_oob",   32'(oob_err), 32'd0);
    chk("mrst_fen",   32'(fetch_enable_o), 32'd0);
    tick; reset = 1'b0; #2;
    chk("mrst_rel_ready", 32'(bif.load_ready), 32'd0);
    tick; #2;
    chk("mrst_ready_up", 32'(bif.load_ready), 32'd1);
    tick; bif.load_valid = 1'b1; bif.load_data = 32'hC0C0_0000; bif.load_last = 1'b1; #2;
    chk("c0_addr0", 32'(sram_addr0), 32'd0);
    chk("c0_din0",  sram_din0, 32'hC0C0_0000);
    tick; bif.load_valid = 1'b0; bif.load_last = 1'b0;
    tick; #2;
    chk("c_fen", 32'(fetch_enable_o), 32'd1);
    tick; bif.instr_req_i = 1'b1; bif.instr_addr_i = 32'h0; #2;
    tick; bif.instr_addr_i = 32'h4; #2;
    chk("c_rdata0", bif.instr_rdata_o, 32'hC0C0_0000);
    tick; bif.instr_req_i = 1'b0; bif.instr_addr_i = 32'h0; #2;
    chk("c_rdata1_kept", bif.instr_rdata_o, 32'hB0B0_0001);
    tick;

    // load_start in RUN with nothing pending, then a full 256-word load
    tick; load_start = 1'b1; bif.instr_req_i = 1'b1; #2;
    chk("ls2_gnt", 32'(bif.instr_gnt_o), 32'd0);
    tick; load_start = 1'b0; bif.instr_req_i = 1'b0; #2;
    chk("ls2_ready", 32'(bif.load_ready), 32'd1);
    chk("ls2_fen",   32'(fetch_enable_o), 32'd0);
    base = wr_count;
    for (int i = 0; i < 256; i++) begin
      tick; bif.load_valid = 1'b1; bif.load_data = 32'h1000_0000 + 32'(i); #2;
      chk("full_addr0", 32'(sram_addr0), 32'(i));
    end
    tick; bif.load_data = 32'hDEAD_BEEF; #2;
    chk("full_ready_low", 32'(bif.load_ready), 32'd0);
    chk("full_no_write",  32'(sram_csb0), 32'd1);
    tick; bif.load_valid = 1'b0; #2;
    chk("full_fen",  32'(fetch_enable_o), 32'd1);
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_wr_count", 32'(wr_count - base), 32'd256);
    tick; bif.instr_req_i = 1'b1; bif.instr_addr_i = 32'h3FC; #2;
    chk("full_gnt", 32'(bif.instr_gnt_o), 32'd1);
    tick; bif.instr_addr_i = 32'h1; #2;
    chk("full_rdata_ff", bif.instr_rdata_o, 32'h1000_00FF);
    tick; bif.instr_req_i = 1'b0; bif.instr_addr_i = 32'h0; #2;
    chk("full_rdata_00", bif.instr_rdata_o, 32'h1000_0000);
    chk("full_oob_clear", 32'(oob_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_bridge.md
Name: instr_mem_bridge

Overview:
Instruction-side memory stage that sits between the ibex instruction fetch port and a dedicated sky130_sram_1kbyte_1rw1r_32x256_8 instruction RAM. This frees the fabric user I/O currently spent on instruction fetch. It first boot-loads the RAM from a 32-bit valid/ready word stream through SRAM port 0. It then releases the core via fetch_enable_o and serves req/gnt/rvalid fetches from SRAM port 1 with one-cycle read latency.

Parameters:
ADDR_W, 8, SRAM word-address width (256 words x 32 bits).
BOOT_WORDS, 256, words loaded before auto-completion; legal range 1..2^ADDR_W.

Ports:
clk  in  1  single clock for all logic and both SRAM ports
reset  in  1  asynchronous, active-high reset
load_start  in  1  one-cycle pulse: (re)enter LOAD, write pointer to 0
load_valid  in  1  boot word valid
load_data  in  32  boot word
load_last  in  1  marks final boot word (early completion)
load_ready  out  1  boot word accepted this cycle
load_done  out  1  high in RUN
fetch_enable_o  out  1  to ibex fetch_enable_i
oob_err  out  1  sticky: fetch above RAM range seen
instr_req_i  in  1  ibex fetch request
instr_addr_i  in  32  ibex byte address
instr_gnt_o  out  1  request accepted
instr_rvalid_o  out  1  read data valid
instr_rdata_o  out  32  read data
sram_csb0  out  1  port-0 chip select, active low
sram_web0  out  1  port-0 write enable, active low
sram_wmask0  out  4  port-0 byte mask
sram_addr0  out  ADDR_W  port-0 address
sram_din0  out  32  port-0 write data
sram_csb1  out  1  port-1 chip select, active low
sram_addr1  out  ADDR_W  port-1 address
sram_dout1  in  32  port-1 read data

Behaviour:
- Reset values:
  - state=LOAD, wptr=0.
  - load_ready=0, load_done=0, fetch_enable_o=0, oob_err=0.
  - gnt=0, rvalid=0, rdata=0.
  - csb0=1, web0=1, wmask0=0, csb1=1. Other SRAM outputs are 0.
- States:
  - LOAD: load_ready=1 (registered, asserted the cycle after reset release).
  - DRAIN: waits for the outstanding fetch to return.
  - RUN.
- LOAD:
  - Handshake: load_valid&&load_ready writes the word in the same cycle: csb0=0, web0=0, wmask0=4'hF, addr0=wptr, din0=load_data. Port-0 outputs are combinational from the handshake.
  - wptr increments per accepted word.
  - Transition to RUN on the next edge if the accepted word has load_last=1 or wptr==BOOT_WORDS-1.
  - wptr never wraps. In RUN it holds its last value until load_start.
- RUN:
  - load_done=1, fetch_enable_o=1 (registered; first asserted the cycle after entry). load_ready=0.
  - instr_gnt_o = instr_req_i (combinational, zero wait).
  - On grant: csb1=0, addr1=instr_addr_i[ADDR_W+1:2]. Bits [1:0] are ignored.
  - instr_rvalid_o is asserted exactly 1 cycle after each grant, with instr_rdata_o=sram_dout1.
  - Back-to-back grants give back-to-back rvalid.
- Out of range:
  - If instr_addr_i[31:ADDR_W+2]!=0, the request is granted but the SRAM is not selected.
  - rvalid then returns 32'h0000_0013 (NOP) and oob_err sets; oob_err clears only on reset.
- load_start:
  - Any state: fetch_enable_o drops next cycle, gnt forced 0 from the load_start cycle onward, wptr<=0.
  - If an rvalid is pending, the state goes to DRAIN. The pending rvalid is still delivered, then the state moves to LOAD.
  - Otherwise the state goes directly to LOAD.
  - load_start in LOAD restarts the pointer. A word accepted in the same cycle is written at wptr and discarded logically, because wptr restarts at 0.
- Port usage: port 0 is never active in RUN; port 1 is never active outside RUN.
- Reset mid-load or mid-fetch: all state clears immediately. Any pending rvalid is lost. SRAM contents are not cleared.

Test Plan:
- Reset, stream 4 words A0..A3 with load_last on A3 → writes at addr0 0..3, load_done=1 and fetch_enable_o=1 two cycles after A3 accepted.
- Stream 256 words with load_last=0 → auto RUN after word 255; load_ready=0 thereafter; no 257th write.
- RUN, req held 3 cycles at addrs 0x0, 0x4, 0xC → gnt each cycle, rvalid in following 3 cycles with A0, A1, A3.
- Fetch at 0x400 → gnt, csb1 stays 1, rvalid with 0x00000013, oob_err=1 and sticky.
- load_start in the same cycle as a req, with rvalid pending from the previous cycle → no gnt, pending rvalid delivered, then LOAD with load_ready=1 and fetch_enable_o=0.
- Assert reset mid-load after 2 words → all outputs at reset values; reload from addr 0 succeeds.
